// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial add/subtract controller and its carry cell.
package serial_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// Single-bit Mealy full-adder stage: combinational sum, one registered carry.
module serial_fa_cell
  import serial_add_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic init_carry,
  input  logic en,
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry_q,
  output logic carry_out
);

  assign sum       = a ^ b ^ carry_q;
  assign carry_out = maj3(a, b, carry_q);

  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      carry_q <= 1'b0;
    end else if (load) begin
      carry_q <= init_carry;
    end else if (en) begin
      carry_q <= carry_out;
    end
  end

endmodule

// File: rtl/serial_add_controller.sv
// Parallel start/busy/done wrapper around a bit-serial adder: shifts operands LSB-first
// through serial_fa_cell and reassembles result, carry-out and signed overflow.
module serial_add_controller
  import serial_add_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [CNT_W-1:0] cnt;

  logic accept;
  logic shifting;
  logic sum_bit;
  logic c_msb_in;
  logic carry_out;

  assign accept   = start && (state == ST_IDLE || state == ST_DONE);
  assign shifting = (state == ST_SHIFT);

  // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
  serial_fa_cell u_cell (
    .clk        (clk),
    .rst        (rst),
    .load       (accept),
    .init_carry (sub == OP_SUB),
    .en         (shifting),
    .a          (a_sh[0]),
    .b          (b_sh[0]),
    .sum        (sum_bit),
    .carry_q    (c_msb_in),
    .carry_out  (carry_out)
  );

  // While on the last bit, carry_q is the carry into the MSB and carry_out the carry out of it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: datapath registers are reset too, so an aborted operation leaves no stale bits behind.
      state  <= ST_IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (accept) begin
            a_sh  <= a_in;
            b_sh  <= (sub == OP_SUB) ? ~b_in : b_in;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_SHIFT;
          end else begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          res_sh <= {sum_bit, res_sh[WIDTH-1:1]};
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          if (cnt == LAST_CNT) begin
            result <= {sum_bit, res_sh[WIDTH-1:1]};
            cout   <= carry_out;
            ovf    <= c_msb_in ^ carry_out;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_controller.sv
// Directed bench for serial_add_controller (WIDTH=8) with hand-computed expectations.
module tb_serial_add_controller;

  logic       clk;
  logic       rst;
  logic       start;
  logic       sub;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       cout;
  logic       ovf;

  int total;
  int bad;

  serial_add_controller #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .sub    (sub),
    .a_in   (a_in),
    .b_in   (b_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus only: issues one operation and reports what was seen. Cycle 1 is the cycle after the accepting edge.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                        output logic [7:0] r, output logic c, output logic o,
                        output int dcyc, output int bcnt, output logic dnext);
    r = 'x; c = 'x; o = 'x; dcyc = 0; bcnt = 0; dnext = 1'b1;
    @(negedge clk);
    a_in = a; b_in = b; sub = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (busy) bcnt++;
      if (done) begin
        dcyc = k; r = result; c = cout; o = ovf;
        break;
      end
      @(posedge clk); #1;
    end
    if (dcyc != 0) begin
      @(posedge clk); #1;
      dnext = done;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; sub = 1'b0; a_in = '0; b_in = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({busy, done, result, cout, ovf} !== 12'h000) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b result=%h cout=%b ovf=%b, want all 0",
               busy, done, result, cout, ovf);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_idle: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic check_op(input string name, input logic [7:0] a, input logic [7:0] b, input logic s,
                          input logic [7:0] er, input logic ec, input logic eo, input logic timing);
    logic [7:0] r;
    logic c, o, dn;
    int dc, bc;
    run_op(a, b, s, r, c, o, dc, bc, dn);
    total++;
    if (r !== er || c !== ec || o !== eo) begin
      bad++;
      $display("FAIL %s: got result=%h cout=%b ovf=%b, want result=%h cout=%b ovf=%b",
               name, r, c, o, er, ec, eo);
    end
    if (timing) begin
      total++;
      if (dc !== 9) begin
        bad++;
        $display("FAIL %s_done_cycle: got %0d, want 9", name, dc);
      end
      total++;
      if (bc !== 8) begin
        bad++;
        $display("FAIL %s_busy_cycles: got %0d, want 8", name, bc);
      end
      total++;
      if (dn !== 1'b0) begin
        bad++;
        $display("FAIL %s_done_pulse: done after pulse got %b, want 0", name, dn);
      end
    end
  endtask

  task automatic test_arith();
    check_op("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 1'b1);
    check_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check_op("sub_10_20", 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b1);
    check_op("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_ignore_start();
    int dcyc;
    dcyc = 0;
    @(negedge clk);
    a_in = 8'h01; b_in = 8'h01; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 4) begin
        @(negedge clk);
        a_in = 8'h55; b_in = 8'h55; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        continue;
      end
      if (done) begin
        dcyc = k;
        break;
      end
      @(posedge clk); #1;
    end
    total++;
    if (dcyc !== 9) begin
      bad++;
      $display("FAIL ignore_done_cycle: got %0d, want 9", dcyc);
    end
    total++;
    if (result !== 8'h02) begin
      bad++;
      $display("FAIL ignore_result: got %h, want 02", result);
    end
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL ignore_no_restart: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_back_to_back();
    int d1, d2;
    logic seen_gap;
    d1 = 0; d2 = 0; seen_gap = 1'b0;
    @(negedge clk);
    a_in = 8'h10; b_in = 8'h20; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a_in = 8'h03; b_in = 8'h04;
    for (int k = 1; k <= 40; k++) begin
      if (done && d1 == 0) begin
        d1 = k;
        total++;
        if (result !== 8'h30) begin
          bad++;
          $display("FAIL b2b_first_result: got %h, want 30", result);
        end
      end else if (d1 != 0 && k == d1 + 1) begin
        start = 1'b0;
        if (!busy) seen_gap = 1'b1;
      end else if (d1 != 0 && k == d1 + 4) begin
        total++;
        if (result !== 8'h30) begin
          bad++;
          $display("FAIL b2b_result_held: got %h, want 30", result);
        end
      end else if (done && d1 != 0) begin
        d2 = k;
        break;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    total++;
    if (d1 !== 9 || d2 !== 18) begin
      bad++;
      $display("FAIL b2b_done_cycles: got %0d and %0d, want 9 and 18", d1, d2);
    end
    total++;
    if (seen_gap !== 1'b0) begin
      bad++;
      $display("FAIL b2b_no_gap: busy got 0 the cycle after done, want 1");
    end
    total++;
    if (result !== 8'h07) begin
      bad++;
      $display("FAIL b2b_second_result: got %h, want 07", result);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    a_in = 8'hFF; b_in = 8'hFF; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    #2 rst = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 8'h00 || cout !== 1'b0 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: got busy=%b done=%b result=%h cout=%b ovf=%b, want all 0",
               busy, done, result, cout, ovf);
    end
    @(negedge clk); rst = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      total++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        bad++;
        $display("FAIL reset_no_resume: got busy=%b done=%b, want 0 0", busy, done);
      end
    end
    check_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_arith();
    test_ignore_start();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
